// File: rtl/stream_pkt_tx.sv
// stream_pkt_tx: command-driven packet source for one crossbar input.
// Each accepted command becomes one packet of len+1 payload beats
// (seed, seed+1, ...) tagged with a constant destination; commands that
// name a nonexistent output are dropped with a one-cycle err_o pulse.
// Optional feature macro: STREAM_PKT_TX_HDR_EN adds a leading header beat
// carrying the command length.
//
// Handshake: a beat transfers on a rising edge where m_valid_o && m_ready_i;
// a command is taken on a rising edge where cmd_valid_i && cmd_ready_o.
// Once raised, m_valid_o and the beat fields hold until the beat transfers.
module stream_pkt_tx #(
    parameter int T_DATA_WIDTH = 8,
    parameter int M_DATA_COUNT = 3,
    parameter int LEN_WIDTH    = 8,
    parameter int CNT_WIDTH    = 16,
    localparam int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DEST_WIDTH-1:0] cmd_dest_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    input  logic [T_DATA_WIDTH-1:0] cmd_seed_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic [T_DEST_WIDTH-1:0] m_dest_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    busy_o,
    output logic                    err_o,
    output logic [CNT_WIDTH-1:0]    pkt_cnt_o,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef STREAM_PKT_TX_HDR_EN
        HDR  = 2'd1,
`endif
        SEND = 2'd2
    } state_t;

    // One extra bit so the range check also works when M_DATA_COUNT is a power of two.
    localparam logic [T_DEST_WIDTH:0] DEST_LIMIT = (T_DEST_WIDTH + 1)'(M_DATA_COUNT);

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [T_DATA_WIDTH-1:0] seed_q, seed_d;
    logic [LEN_WIDTH-1:0]    k_q, k_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [T_DEST_WIDTH-1:0] m_dest_q, m_dest_d;
    logic                    m_last_q, m_last_d;
    logic                    m_valid_q, m_valid_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [CNT_WIDTH-1:0]    pkt_cnt_q, pkt_cnt_d;

    logic                    cmd_fire;
    logic                    beat_fire;
    logic                    dest_bad;
    logic [LEN_WIDTH-1:0]    k_inc;

    assign cmd_fire  = cmd_valid_i && cmd_ready_q;
    assign beat_fire = m_valid_q && m_ready_i;
    assign dest_bad  = {1'b0, cmd_dest_i} >= DEST_LIMIT;
    assign k_inc     = k_q + LEN_WIDTH'(1);

    // Next-state and next-output computation; every output is prepared one cycle ahead.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        seed_d      = seed_q;
        k_d         = k_q;
        cmd_ready_d = cmd_ready_q;
        m_data_d    = m_data_q;
        m_dest_d    = m_dest_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;
        busy_d      = busy_q;
        err_d       = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    len_d  = cmd_len_i;
                    seed_d = cmd_seed_i;
                    k_d    = '0;
                    if (dest_bad) begin
                        err_d = 1'b1;
                    end else begin
                        m_dest_d    = cmd_dest_i;
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                        m_valid_d   = 1'b1;
`ifdef STREAM_PKT_TX_HDR_EN
                        state_d  = HDR;
                        m_data_d = T_DATA_WIDTH'(cmd_len_i);
                        m_last_d = 1'b0;
`else
                        state_d  = SEND;
                        m_data_d = cmd_seed_i;
                        m_last_d = (cmd_len_i == '0);
`endif
                    end
                end
            end
`ifdef STREAM_PKT_TX_HDR_EN
            HDR: begin
                if (beat_fire) begin
                    state_d  = SEND;
                    k_d      = '0;
                    m_data_d = seed_q;
                    m_last_d = (len_q == '0);
                end
            end
`endif
            SEND: begin
                if (beat_fire) begin
                    if (m_last_q) begin
                        state_d     = IDLE;
                        m_valid_d   = 1'b0;
                        m_last_d    = 1'b0;
                        cmd_ready_d = 1'b1;
                        busy_d      = 1'b0;
                        pkt_cnt_d   = pkt_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        k_d      = k_inc;
                        m_data_d = seed_q + T_DATA_WIDTH'(k_inc);
                        m_last_d = (k_inc == len_q);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                m_valid_d   = 1'b0;
                m_last_d    = 1'b0;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            seed_q      <= '0;
            k_q         <= '0;
            cmd_ready_q <= 1'b1;
            m_data_q    <= '0;
            m_dest_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            seed_q      <= seed_d;
            k_q         <= k_d;
            cmd_ready_q <= cmd_ready_d;
            m_data_q    <= m_data_d;
            m_dest_q    <= m_dest_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign m_data_o    = m_data_q;
    assign m_dest_o    = m_dest_q;
    assign m_last_o    = m_last_q;
    assign m_valid_o   = m_valid_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign pkt_cnt_o   = pkt_cnt_q;
    assign state_o     = state_q;

endmodule
